// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, multiply/divide state encoding and datapath width.
package alu_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;
   localparam logic [3:0] OP_NEG = 4'b1010;
   localparam logic [3:0] OP_NOT = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_SIGN  = 2'd2,
      ST_DZERO = 2'd3
   } md_state_e;

endpackage

// File: rtl/addsub_33.sv
// Shared adder/subtractor: MUL accumulate step and DIV trial subtract.
module addsub_33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/muldiv_32.sv
// Multi-cycle signed multiply/divide unit; shift-add MUL and restoring DIV on
// magnitudes, with the sign fix-up applied in a final cycle.
//
//  state    | meaning
//  ST_IDLE  | waiting for a MUL/DIV start
//  ST_CALC  | one multiply/quotient bit per cycle, WIDTH cycles
//  ST_SIGN  | apply result signs, write HI/LO, pulse done
//  ST_DZERO | divide by zero: write fixed result and flag
module muldiv_32
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_start,
   input  logic [3:0]       in_opcode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_busy,
   output logic             out_done,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo,
   output logic             out_div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e state_q, state_d;

   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   p_hi_q, p_lo_q;
   logic               is_div_q, neg_res_q, neg_div_q;

   logic               accept, is_div_req;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_a, add_b, add_sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_div_req = (in_opcode == OP_DIV);
   assign accept     = (state_q == ST_IDLE) && in_start
                       && ((in_opcode == OP_MUL) || is_div_req);
   assign mag_a      = in_a[WIDTH-1] ? (~in_a + 1'b1) : in_a;
   assign mag_b      = in_b[WIDTH-1] ? (~in_b + 1'b1) : in_b;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (is_div_req && (in_b == '0)) ? ST_DZERO : ST_CALC;
         ST_CALC:  if (cnt_q == '0) state_d = ST_SIGN;
         ST_SIGN:  state_d = ST_IDLE;
         ST_DZERO: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // DIV shifts the next dividend bit into the partial remainder before the trial subtract.
   always_comb begin
      add_a = {1'b0, p_hi_q};
      add_b = p_lo_q[0] ? {1'b0, opnd_q} : '0;
      if (is_div_q) begin
         add_a = {p_hi_q, p_lo_q[WIDTH-1]};
         add_b = {1'b0, opnd_q};
      end
   end

   addsub_33 #(.W(WIDTH + 1)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (is_div_q),
      .sum (add_sum)
   );

   assign prod_fix = neg_res_q ? (~{p_hi_q, p_lo_q} + 1'b1) : {p_hi_q, p_lo_q};
   assign quo_fix  = neg_res_q ? (~p_lo_q + 1'b1) : p_lo_q;
   assign rem_fix  = neg_div_q ? (~p_hi_q + 1'b1) : p_hi_q;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         opnd_q          <= '0;
         p_hi_q          <= '0;
         p_lo_q          <= '0;
         is_div_q        <= 1'b0;
         neg_res_q       <= 1'b0;
         neg_div_q       <= 1'b0;
         out_busy        <= 1'b0;
         out_done        <= 1'b0;
         out_hi          <= '0;
         out_lo          <= '0;
         out_div_by_zero <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  is_div_q        <= is_div_req;
                  neg_res_q       <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                  neg_div_q       <= in_a[WIDTH-1];
                  cnt_q           <= CNT_LAST;
                  out_busy        <= 1'b1;
                  out_div_by_zero <= 1'b0;
                  if (is_div_req) begin
                     // raw dividend parked in p_hi for the divide-by-zero result
                     opnd_q <= mag_b;
                     p_hi_q <= (in_b == '0) ? in_a : '0;
                     p_lo_q <= mag_a;
                  end else begin
                     opnd_q <= mag_a;
                     p_hi_q <= '0;
                     p_lo_q <= mag_b;
                  end
               end
            end
            ST_CALC: begin
               cnt_q <= cnt_q - 1'b1;
               if (is_div_q) begin
                  p_hi_q <= add_sum[WIDTH] ? {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]}
                                           : add_sum[WIDTH-1:0];
                  p_lo_q <= {p_lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
               end else begin
                  p_hi_q <= add_sum[WIDTH:1];
                  p_lo_q <= {add_sum[0], p_lo_q[WIDTH-1:1]};
               end
            end
            ST_SIGN: begin
               out_busy <= 1'b0;
               out_done <= 1'b1;
               if (is_div_q) begin
                  out_hi <= rem_fix;
                  out_lo <= quo_fix;
               end else begin
                  out_hi <= prod_fix[2*WIDTH-1:WIDTH];
                  out_lo <= prod_fix[WIDTH-1:0];
               end
            end
            ST_DZERO: begin
               out_busy        <= 1'b0;
               out_done        <= 1'b1;
               out_hi          <= p_hi_q;
               out_lo          <= '1;
               out_div_by_zero <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_32.sv
// Bench for muldiv_32: signed-arithmetic reference model checked every cycle,
// directed literal cases and randomized traffic.
module tb_muldiv_32;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  opcode = 4'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit          m_busy = 0, m_done = 0, m_dbz = 0, n_dbz = 0;
   logic [31:0] m_hi = '0, m_lo = '0, n_hi = '0, n_lo = '0;
   int          m_rem = 0;

   muldiv_32 dut (
      .in_clk          (clk),
      .in_rst_n        (rst_n),
      .in_start        (start),
      .in_opcode       (opcode),
      .in_a            (a),
      .in_b            (b),
      .out_busy        (busy),
      .out_done        (done),
      .out_hi          (hi),
      .out_lo          (lo),
      .out_div_by_zero (dbz)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_rem = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 0; m_done = 1; m_hi = n_hi; m_lo = n_lo; m_dbz = n_dbz;
            end
         end else if (start && (opcode == OP_MUL || opcode == OP_DIV)) begin
            int      sa, sb;
            longint  p;
            sa = $signed(a);
            sb = $signed(b);
            n_dbz = 0;
            m_rem = 33;
            if (opcode == OP_MUL) begin
               p = longint'(sa) * longint'(sb);
               n_hi = p[63:32];
               n_lo = p[31:0];
            end else if (sb == 0) begin
               n_hi = a; n_lo = 32'hFFFF_FFFF; n_dbz = 1; m_rem = 1;
            end else if (a == 32'h8000_0000 && sb == -1) begin
               n_hi = '0; n_lo = 32'h8000_0000;
            end else begin
               n_lo = sa / sb;
               n_hi = sa % sb;
            end
            m_busy = 1;
            m_dbz  = 0;
         end
      end
   end

   always @(negedge clk) begin
      vectors++;
      if ({busy, done, dbz, hi, lo} !== {m_busy, m_done, m_dbz, m_hi, m_lo}) begin
         miscompares++;
         $display("FAIL cycle_check t=%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                  $time, busy, done, dbz, hi, lo, m_busy, m_done, m_dbz, m_hi, m_lo);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int max, output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done && lat < max);
   endtask

   // called at posedge+1; returns at posedge+1 of the done edge
   task automatic do_op(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        output int lat);
      start = 1; opcode = op; a = oa; b = ob;
      @(posedge clk); #1;
      start = 0; a = $urandom; b = $urandom; opcode = 4'($urandom);
      chk("busy_at_accept", {31'b0, busy}, 32'd1);
      wait_done(40, lat);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, seen;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_dbz", {31'b0, dbz}, 32'd0);
      @(posedge clk); #1;

      do_op(OP_MUL, 32'd6, 32'hFFFF_FFF9, lat);
      chk("mul_lat", lat, 32'd33);
      chk("mul_neg_hi", hi, 32'hFFFF_FFFF);
      chk("mul_neg_lo", lo, 32'hFFFF_FFD6);

      do_op(OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
      chk("mul_max_hi", hi, 32'h3FFF_FFFF);
      chk("mul_max_lo", lo, 32'h0000_0001);
      do_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, lat);
      chk("mul_min_hi", hi, 32'h4000_0000);
      chk("mul_min_lo", lo, 32'h0);

      // second op started in the done cycle of the first
      do_op(OP_DIV, 32'hFFFF_FFEF, 32'd5, lat);
      chk("div_neg_lo", lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi, 32'hFFFF_FFFE);
      do_op(OP_DIV, 32'd100, 32'd7, lat);
      chk("b2b_lat", lat, 32'd33);
      chk("div_pos_lo", lo, 32'd14);
      chk("div_pos_hi", hi, 32'd2);

      do_op(OP_DIV, 32'h0000_1234, 32'd0, lat);
      chk("dz_lat", lat, 32'd1);
      chk("dz_flag", {31'b0, dbz}, 32'd1);
      chk("dz_hi", hi, 32'h1234);
      chk("dz_lo", lo, 32'hFFFF_FFFF);
      start = 1; opcode = OP_MUL; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      start = 0;
      chk("dz_cleared", {31'b0, dbz}, 32'd0);
      wait_done(40, lat);
      chk("mul_small_lo", lo, 32'd12);

      @(posedge clk); #1;
      start = 1; opcode = OP_ADD; a = 32'd5; b = 32'd5;
      @(posedge clk); #1;
      start = 0;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (busy || done) seen++;
      end
      chk("ignored_op", seen, 32'd0);

      start = 1; opcode = OP_MUL; a = 32'h0001_2345; b = 32'h0000_0777;
      @(posedge clk); #1;
      start = 0;
      repeat (10) @(posedge clk);
      #1 start = 1; opcode = OP_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 0;
      wait_done(40, lat);
      chk("midcalc_lat", lat, 32'd22);
      chk("midcalc_hi", hi, 32'h0);
      chk("midcalc_lo", lo, 32'h087E_4813);

      @(posedge clk); #1;
      start = 1; opcode = OP_MUL; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      start = 0;
      repeat (10) @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(posedge clk); #1 rst_n = 1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("rst_no_done", seen, 32'd0);

      for (int i = 0; i < 4000; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 7))
            0, 1, 2: opcode = OP_MUL;
            3, 4, 5: opcode = OP_DIV;
            default: opcode = 4'($urandom);
         endcase
         a = pick();
         b = pick();
         @(posedge clk); #1;
      end
      start = 0;
      repeat (40) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_32.md
Name: muldiv_32

Overview:
Multi-cycle signed multiply/divide unit for the 32-bit datapath. It executes the two opcodes that the combinational ALU reserves but leaves unimplemented: 4'b1000 MUL and 4'b1001 DIV. The control sequencer issues a start pulse with operands and opcode, then waits on busy/done. The 64-bit result is written to the HI/LO register pair.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH wide (HI, LO); iteration count equals WIDTH.

Ports:
in_clk  input  1  system clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_start  input  1  request strobe; sampled only in IDLE
in_opcode  input  4  4'b1000 MUL, 4'b1001 DIV; any other value is ignored
in_a  input  32  multiplicand / dividend (two's complement)
in_b  input  32  multiplier / divisor (two's complement)
out_busy  output  1  high while an operation is in progress
out_done  output  1  one-cycle pulse when out_hi/out_lo are updated
out_hi  output  32  MUL: product[63:32]; DIV: remainder
out_lo  output  32  MUL: product[31:0]; DIV: quotient
out_div_by_zero  output  1  set with done when a DIV had in_b==0; cleared at next accept

Behaviour:
- Reset (async, in_rst_n=0): state IDLE; out_busy, out_done, out_hi, out_lo, out_div_by_zero all 0.
- Accept condition: state IDLE and in_start=1 and in_opcode is MUL or DIV. On that rising edge (edge k):
  - latch |in_a|, |in_b|, the result sign, the dividend sign, and the op;
  - clear out_div_by_zero;
  - out_busy=1 from k onward.
- Ignored requests: a start with any other opcode, or any start while busy, is ignored with no side effects.
- States:
  - IDLE -> CALC on accept.
  - IDLE -> DZERO on accept when op=DIV and in_b==0.
  - CALC -> CALC for WIDTH iterations (iteration counter 0..WIDTH-1), then -> SIGN.
  - SIGN -> IDLE.
  - DZERO -> IDLE.
- Algorithms:
  - MUL: unsigned shift-add on magnitudes, one bit per cycle, 64-bit accumulator.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. Uses a 33-bit partial-remainder subtract; the sign of the difference decides restore.
- SIGN cycle:
  - MUL: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Writes out_hi/out_lo, pulses out_done=1, drops out_busy to 0.
- Latency:
  - Normal op: accept at edge k; results registered and done=1 at edge k+WIDTH+1 (k+33 for WIDTH=32), with done lasting one cycle.
  - DZERO: done at edge k+1, out_hi=in_a as latched, out_lo=all ones, out_div_by_zero=1.
- Back-to-back: the state is IDLE during the done cycle, so a start sampled in that cycle is accepted and the next operation begins immediately.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives out_lo=0x80000000, out_hi=0. This falls out of the magnitude arithmetic; no flag is raised.
- Result hold: out_hi/out_lo hold their values until the next done. They do not change during CALC.
- Reset mid-operation aborts immediately: outputs return to 0 and no done pulse is issued.
- Operands are sampled only at accept; changes on in_a/in_b/in_opcode while busy have no effect.

Decomposition:
- Shared package alu_pkg:
  - the full 4-bit ALU opcode constants (ADD 0000 ... MUL 1000, DIV 1001, NEG 1010, NOT 1011);
  - the muldiv state encoding (IDLE, CALC, SIGN, DZERO);
  - DATA_WIDTH=32.
- One natural sub-module: addsub_33, a 33-bit add/subtract shared by the MUL accumulate step and the DIV trial subtract.
- Sign-fix negation stays inline.

Test Plan:
- MUL 6 x 0xFFFFFFF9 (-7) -> done 33 cycles after accept; out_hi=0xFFFFFFFF, out_lo=0xFFFFFFD6; busy high for exactly 33 cycles.
- MUL 0x7FFFFFFF x 0x7FFFFFFF -> out_hi=0x3FFFFFFF, out_lo=0x00000001; then MUL 0x80000000 x 0x80000000 -> out_hi=0x40000000, out_lo=0.
- DIV 0xFFFFFFEF (-17) / 5 -> out_lo=0xFFFFFFFD (-3), out_hi=0xFFFFFFFE (-2); DIV 100/7 -> out_lo=14, out_hi=2.
- DIV 0x00001234 / 0 -> done 1 cycle after accept; out_div_by_zero=1, out_hi=0x1234, out_lo=0xFFFFFFFF; next accepted MUL clears the flag.
- Ignored requests: start with opcode 4'b0000 -> busy stays 0, no done. Start pulsed mid-CALC with new operands -> ignored; the original result is unchanged.
- Reset and back-to-back: in_rst_n low at iteration 10 -> all outputs 0 immediately, no done. Start asserted during the done cycle -> second op accepted and its done arrives 33 cycles later.
